// File: rtl/cnn_pkg.sv
// Shared widths, geometry and pixel/weight types for the streaming convolution front end.
package cnn_pkg;

  localparam int unsigned I_F_BW  = 8;
  localparam int unsigned O_F_BW  = 23;
  localparam int unsigned KX      = 5;
  localparam int unsigned KY      = 5;
  localparam int unsigned W_BW    = 7;
  localparam int unsigned CI      = 1;
  localparam int unsigned CO      = 1;
  localparam int unsigned IX      = 28;
  localparam int unsigned IY      = 28;

  localparam int unsigned NTAP    = KX * KY;
  localparam int unsigned PROD_BW = I_F_BW + 1 + W_BW;
  localparam int unsigned ACC_BW  = I_F_BW + 1 + W_BW + $clog2(KX * KY) + 1;
  localparam int unsigned XW      = $clog2(IX);
  localparam int unsigned YW      = $clog2(IY);

  typedef logic [I_F_BW-1:0]         pixel_t;
  typedef logic signed [W_BW-1:0]    weight_t;
  typedef logic signed [PROD_BW-1:0] prod_t;
  typedef logic signed [ACC_BW-1:0]  acc_t;

  // Unsigned pixel (zero-extended) times signed weight; the full product fits in PROD_BW.
  function automatic prod_t tap_mul(input pixel_t p, input weight_t w);
    prod_t pe;
    prod_t we;
    pe = PROD_BW'($signed({1'b0, p}));
    we = PROD_BW'(w);
    return pe * we;
  endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// KY-1 circular row buffers of depth IX, addressed by the current column.
// Reading gives the column above x (oldest row first) with the incoming pixel as the newest entry.
module cnn_line_buffer
  import cnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [XW-1:0]          x_i,
  input  pixel_t                 pixel_i,
  output logic [KY*I_F_BW-1:0]   col_c_o
);

  // Storage only; stale contents are masked downstream by the window valid.
  pixel_t mem_q [KY-1][IX];

  // Column at x: buffered rows plus the live pixel on top.
  always_comb begin
    col_c_o = '0;
    for (int r = 0; r < int'(KY) - 1; r++) begin
      col_c_o[r*I_F_BW +: I_F_BW] = mem_q[r][x_i];
    end
    col_c_o[(KY-1)*I_F_BW +: I_F_BW] = pixel_i;
  end

  // On accept, each row slot at x ages by one row and the new pixel enters the youngest buffer.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int r = 0; r < int'(KY) - 2; r++) begin
        mem_q[r][x_i] <= mem_q[r+1][x_i];
      end
      mem_q[KY-2][x_i] <= pixel_i;
    end
  end

endmodule

// File: rtl/cnn_window_conv.sv
// Streaming KXxKY window extraction and CO-channel convolution with bias.
// Window and line-buffer column register on the accepting edge; conv is two stages later.
// Build option: define CNN_RELU_EN to clamp each channel result at zero (same latency).
module cnn_window_conv
  import cnn_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_valid,
  input  logic [I_F_BW-1:0]             i_pixel,
  input  logic [CO*CI*KX*KY*W_BW-1:0]   i_cnn_weight,
  input  logic [CO*W_BW-1:0]            i_cnn_bias,
  output logic [KX*KY*I_F_BW-1:0]       o_window,
  output logic [KY*I_F_BW-1:0]          o_line_buf,
  output logic                          o_win_valid,
  output logic [CO*O_F_BW-1:0]          o_conv,
  output logic                          o_conv_valid,
  output logic                          o_done
);

  if (CI != 1) begin : g_ci_check
    $error("cnn_window_conv supports CI=1 only");
  end

  logic                  accept_c;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [KY*I_F_BW-1:0]  col_c;
  pixel_t                win_q [NTAP];
  pixel_t                win_d [NTAP];
  logic [KY*I_F_BW-1:0]  lb_q, lb_d;
  logic                  wv_q, wv_d;
  logic                  wlast_q, wlast_d;
  prod_t                 prod_q [CO][NTAP];
  prod_t                 prod_d [CO][NTAP];
  logic                  s1_valid_q, s1_last_q;
  acc_t                  acc_c [CO];
  logic [O_F_BW-1:0]     conv_q [CO];
  logic [O_F_BW-1:0]     conv_d [CO];
  logic                  cv_q, done_q;

  assign accept_c = i_valid & ~reset;

  cnn_line_buffer u_line_buffer (
    .clk     (clk),
    .we_i    (accept_c),
    .x_i     (x_q),
    .pixel_i (i_pixel),
    .col_c_o (col_c)
  );

  // Raster counters, window shift and window-valid qualification.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    win_d   = win_q;
    lb_d    = lb_q;
    wv_d    = 1'b0;
    wlast_d = 1'b0;
    if (accept_c) begin
      if (x_q == XW'(IX - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(IY - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      for (int r = 0; r < int'(KY); r++) begin
        for (int c = 0; c < int'(KX) - 1; c++) begin
          win_d[r*KX + c] = win_q[r*KX + c + 1];
        end
        win_d[r*KX + KX - 1] = col_c[r*I_F_BW +: I_F_BW];
      end
      lb_d    = col_c;
      wv_d    = (x_q >= XW'(KX - 1)) && (y_q >= YW'(KY - 1));
      wlast_d = (x_q == XW'(IX - 1)) && (y_q == YW'(IY - 1));
    end
  end

  // Stage 1: per-tap products for every output channel.
  always_comb begin
    for (int co = 0; co < int'(CO); co++) begin
      for (int i = 0; i < int'(NTAP); i++) begin
        prod_d[co][i] = tap_mul(win_q[i],
                                weight_t'(i_cnn_weight[(co*NTAP + i)*W_BW +: W_BW]));
      end
    end
  end

  // Stage 2: sum of products plus sign-extended bias, optionally clamped at zero.
  always_comb begin
    for (int co = 0; co < int'(CO); co++) begin
      acc_c[co] = acc_t'(weight_t'(i_cnn_bias[co*W_BW +: W_BW]));
      for (int i = 0; i < int'(NTAP); i++) begin
        acc_c[co] = acc_c[co] + acc_t'(prod_q[co][i]);
      end
`ifdef CNN_RELU_EN
      if (acc_c[co] < 0) begin
        acc_c[co] = '0;
      end
`endif
      conv_d[co] = O_F_BW'(acc_c[co]);
    end
  end

  // All state registers; reset clears counters, outputs and pipeline valids.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      win_q      <= '{default: '0};
      lb_q       <= '0;
      wv_q       <= 1'b0;
      wlast_q    <= 1'b0;
      prod_q     <= '{default: '{default: '0}};
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      conv_q     <= '{default: '0};
      cv_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      win_q      <= win_d;
      lb_q       <= lb_d;
      wv_q       <= wv_d;
      wlast_q    <= wlast_d;
      prod_q     <= prod_d;
      s1_valid_q <= wv_q;
      s1_last_q  <= wlast_q;
      conv_q     <= conv_d;
      cv_q       <= s1_valid_q;
      done_q     <= s1_valid_q & s1_last_q;
    end
  end

  // Output wiring from registered state.
  always_comb begin
    o_window = '0;
    for (int i = 0; i < int'(NTAP); i++) begin
      o_window[i*I_F_BW +: I_F_BW] = win_q[i];
    end
    o_conv = '0;
    for (int co = 0; co < int'(CO); co++) begin
      o_conv[co*O_F_BW +: O_F_BW] = conv_q[co];
    end
  end

  assign o_line_buf   = lb_q;
  assign o_win_valid  = wv_q;
  assign o_conv_valid = cv_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_cnn_window_conv.sv
// Bench for cnn_window_conv: image-level reference model plus hand-computed frame expectations.
// The 1..784 ramp is driven through the 8-bit pixel port, so values above 255 wrap modulo 256.
module tb_cnn_window_conv;
  import cnn_pkg::*;

`ifdef CNN_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         i_valid;
  logic [I_F_BW-1:0]            i_pixel;
  logic [CO*CI*KX*KY*W_BW-1:0]  i_cnn_weight;
  logic [CO*W_BW-1:0]           i_cnn_bias;
  logic [KX*KY*I_F_BW-1:0]      o_window;
  logic [KY*I_F_BW-1:0]         o_line_buf;
  logic                         o_win_valid;
  logic [CO*O_F_BW-1:0]         o_conv;
  logic                         o_conv_valid;
  logic                         o_done;

  cnn_window_conv dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .i_pixel      (i_pixel),
    .i_cnn_weight (i_cnn_weight),
    .i_cnn_bias   (i_cnn_bias),
    .o_window     (o_window),
    .o_line_buf   (o_line_buf),
    .o_win_valid  (o_win_valid),
    .o_conv       (o_conv),
    .o_conv_valid (o_conv_valid),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the image as accepted, and the conv results owed by the DUT.
  typedef struct {int due; int val; bit done;} conv_e_t;
  int       wt [NTAP];
  int       bias;
  int       img [IY][IX];
  int       mx, my;
  bit       exp_wv, exp_lbchk;
  int       exp_win [NTAP];
  int       exp_col [KY];
  conv_e_t  q [$];

  // Observed per-test statistics.
  int       n_conv, n_done, first_conv, last_conv;
  bit       got_win;
  logic [KX*KY*I_F_BW-1:0] first_win;

  task automatic set_coef(input int w, input int b);
    for (int i = 0; i < int'(NTAP); i++) begin
      wt[i] = w;
      i_cnn_weight[i*W_BW +: W_BW] = W_BW'(w);
    end
    bias = b;
    i_cnn_bias = W_BW'(b);
  endtask

  task automatic clear_stats();
    n_conv = 0; n_done = 0; first_conv = 0; last_conv = 0; got_win = 1'b0; first_win = '0;
  endtask

  task automatic model_accept(input int p);
    int sum;
    img[my][mx] = p;
    if (my >= int'(KY) - 1) begin
      exp_lbchk = 1'b1;
      for (int r = 0; r < int'(KY); r++) exp_col[r] = img[my - int'(KY) + 1 + r][mx];
    end
    if (mx >= int'(KX) - 1 && my >= int'(KY) - 1) begin
      exp_wv = 1'b1;
      sum = bias;
      for (int r = 0; r < int'(KY); r++) begin
        for (int c = 0; c < int'(KX); c++) begin
          exp_win[r*KX + c] = img[my - int'(KY) + 1 + r][mx - int'(KX) + 1 + c];
          sum += exp_win[r*KX + c] * wt[r*KX + c];
        end
      end
      if (RELU && sum < 0) sum = 0;
      q.push_back('{cyc + 2, sum, (mx == int'(IX) - 1) && (my == int'(IY) - 1)});
    end
    mx++;
    if (mx == int'(IX)) begin
      mx = 0;
      my = (my == int'(IY) - 1) ? 0 : my + 1;
    end
  endtask

  // One clock: drive inputs, then update the model just after the edge.
  task automatic tick(input bit v, input int p);
    i_valid = v;
    i_pixel = 8'(p);
    @(posedge clk);
    #1;
    exp_wv = 1'b0;
    exp_lbchk = 1'b0;
    if (reset) begin
      mx = 0; my = 0; q.delete();
    end else if (v) begin
      model_accept(p & 255);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick(1'b0, 0);
    reset = 1'b0;
  endtask

  task automatic run_frame(input bit toggle);
    for (int n = 1; n <= int'(IX*IY); n++) begin
      tick(1'b1, n);
      if (toggle) tick(1'b0, 8'hA5);
    end
  endtask

  task automatic flush();
    repeat (6) tick(1'b0, 0);
  endtask

  task automatic check_frame(input string tag, input int f, input int l, input int n, input int d,
                             input bit chk_win);
    logic [I_F_BW-1:0] b;
    chk({tag, "_first_conv"}, first_conv, f);
    chk({tag, "_last_conv"},  last_conv,  l);
    chk({tag, "_n_conv"},     n_conv,     n);
    chk({tag, "_n_done"},     n_done,     d);
    if (chk_win) begin
      for (int c = 0; c < int'(KX); c++) begin
        b = first_win[c*I_F_BW +: I_F_BW];
        chk({tag, "_win_row0"}, int'(b), c + 1);
        b = first_win[(4*KX + c)*I_F_BW +: I_F_BW];
        chk({tag, "_win_row4"}, int'(b), 113 + c);
      end
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit expv;
    int act;
    chk("win_valid", int'(o_win_valid), int'(exp_wv));
    if (exp_wv && o_win_valid) begin
      for (int i = 0; i < int'(NTAP); i++)
        chk("window_px", int'(o_window[i*I_F_BW +: I_F_BW]), exp_win[i]);
      if (!got_win) begin
        got_win = 1'b1;
        first_win = o_window;
      end
    end
    if (exp_lbchk) begin
      for (int r = 0; r < int'(KY); r++)
        chk("line_buf", int'(o_line_buf[r*I_F_BW +: I_F_BW]), exp_col[r]);
    end
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    expv = (q.size() > 0) && (q[0].due == cyc);
    chk("conv_valid", int'(o_conv_valid), int'(expv));
    if (expv) begin
      act = int'($signed(o_conv[O_F_BW-1:0]));
      chk("conv", act, q[0].val);
      chk("done", int'(o_done), int'(q[0].done));
      void'(q.pop_front());
      if (o_conv_valid) begin
        if (n_conv == 0) first_conv = act;
        last_conv = act;
        n_conv++;
      end
    end else begin
      chk("done_idle", int'(o_done), 0);
    end
    n_done += int'(o_done);
  end

  initial begin
    reset = 1'b1;
    i_valid = 1'b0;
    i_pixel = '0;
    mx = 0; my = 0; exp_wv = 1'b0; exp_lbchk = 1'b0;
    set_coef(1, 0);
    clear_stats();
    do_reset(3);

    // Reset values.
    chk("rst_window",   int'(o_window == '0),   1);
    chk("rst_line_buf", int'(o_line_buf == '0), 1);
    chk("rst_conv",     int'(o_conv == '0),     1);
    chk("rst_conv_valid", int'(o_conv_valid), 0);
    chk("rst_done",     int'(o_done), 0);

    // Ramp, unit weights, zero bias.
    clear_stats();
    run_frame(1'b0);
    flush();
    check_frame("ramp", 1475, 4070, 576, 1, 1'b1);

    // Bias 5.
    set_coef(1, 5);
    clear_stats();
    run_frame(1'b0);
    flush();
    check_frame("bias5", 1480, 4075, 576, 1, 1'b0);

    // All weights -1.
    set_coef(-1, 0);
    clear_stats();
    run_frame(1'b0);
    flush();
    check_frame("neg", RELU ? 0 : -1475, RELU ? 0 : -4070, 576, 1, 1'b0);

    // Valid toggling every other cycle.
    set_coef(1, 0);
    clear_stats();
    run_frame(1'b1);
    flush();
    check_frame("gap", 1475, 4070, 576, 1, 1'b1);

    // Reset after 300 pixels, then a fresh ramp.
    for (int n = 1; n <= 300; n++) tick(1'b1, n);
    do_reset(1);
    clear_stats();
    run_frame(1'b0);
    flush();
    check_frame("midrst", 1475, 4070, 576, 1, 1'b1);

    // Two back-to-back frames.
    clear_stats();
    run_frame(1'b0);
    run_frame(1'b0);
    flush();
    check_frame("b2b", 1475, 4070, 1152, 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
